// File: rtl/imul_var_lat_param_pkg.sv
// imul_var_lat_param_pkg
//   Shared definitions for the variable-latency iterative multiplier:
//   operation encodings, FSM state encodings and small decode helpers.
package imul_var_lat_param_pkg;

  // width of the in_func operation selector
  localparam int func_w = 2;

  localparam logic [func_w-1:0] func_mul    = 2'd0;  // low half, sign-agnostic
  localparam logic [func_w-1:0] func_mulh   = 2'd1;  // signed x signed, high half
  localparam logic [func_w-1:0] func_mulhu  = 2'd2;  // unsigned x unsigned, high half
  localparam logic [func_w-1:0] func_mulhsu = 2'd3;  // signed x unsigned, high half

  localparam logic [1:0] st_idle = 2'd0;
  localparam logic [1:0] st_calc = 2'd1;
  localparam logic [1:0] st_fix  = 2'd2;
  localparam logic [1:0] st_done = 2'd3;

  // Operand a is interpreted as signed for MULH and MULHSU.
  function automatic logic func_signed_a(input logic [func_w-1:0] f);
    return (f == func_mulh) || (f == func_mulhsu);
  endfunction

  // Operand b is interpreted as signed for MULH only.
  function automatic logic func_signed_b(input logic [func_w-1:0] f);
    return (f == func_mulh);
  endfunction

endpackage

// File: rtl/imul_var_lat_param_if.sv
// imul_var_lat_param_if
//   Request/response val/rdy bundle for the multiplier.
//   Request : in_val, in_rdy, in_func, in_a, in_b
//   Response: out_val, out_rdy, out_msg
//   master = requester/consumer side, slave = multiplier side.
interface imul_var_lat_param_if
  import imul_var_lat_param_pkg::*;
#(
  parameter int p_nbits = 32
);

  logic                in_val;
  logic                in_rdy;
  logic [func_w-1:0]   in_func;
  logic [p_nbits-1:0]  in_a;
  logic [p_nbits-1:0]  in_b;
  logic                out_val;
  logic                out_rdy;
  logic [p_nbits-1:0]  out_msg;

  modport master (
    output in_val, in_func, in_a, in_b, out_rdy,
    input  in_rdy, out_val, out_msg
  );

  modport slave (
    input  in_val, in_func, in_a, in_b, out_rdy,
    output in_rdy, out_val, out_msg
  );

endinterface

// File: rtl/imul_var_lat_param_tzc.sv
// imul_trailing_zero_count
//   Combinational trailing-zero counter.
//   bits  : input vector, p_nbits_in wide
//   count : index of the lowest set bit, or p_nbits_in when bits == 0
module imul_trailing_zero_count #(
  parameter int p_nbits_in = 8
) (
  input  logic [p_nbits_in-1:0]         bits,
  output logic [$clog2(p_nbits_in):0]   count
);

  localparam int cw = $clog2(p_nbits_in) + 1;

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    count = cw'(p_nbits_in);
    for (int i = p_nbits_in - 1; i >= 0; i--) begin
      if (bits[i]) count = cw'(i);
    end
  end

endmodule

// File: rtl/imul_var_lat_param.sv
// imul_var_lat_param
//   Variable-latency iterative integer multiplier. Works on operand
//   magnitudes with a shift-and-add loop that skips up to p_skip_max zero
//   multiplier bits per cycle, then fixes the sign in a single cycle.
//   Ports:
//     clk   : clock
//     reset : asynchronous, active-high reset
//     io    : request/response bundle (slave side)
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | in_rdy high, waiting for a request
//   CALC  | one shift/add step per cycle until the multiplier is zero
//   FIX   | negate the 2N-bit magnitude product if the signs differ
//   DONE  | out_val high, out_msg held until out_rdy
module imul_var_lat_param
  import imul_var_lat_param_pkg::*;
#(
  parameter int p_nbits    = 32,
  parameter int p_skip_max = 8
) (
  input logic                  clk,
  input logic                  reset,
  imul_var_lat_param_if.slave  io
);

  localparam int zw = $clog2(p_skip_max) + 1;

  logic [1:0]           state;
  logic [2*p_nbits-1:0] a_reg;
  logic [p_nbits-1:0]   b_reg;
  logic [2*p_nbits-1:0] result_reg;
  logic                 neg_reg;
  logic [func_w-1:0]    func_reg;

  // ---------------------------------------------------------------------
  // Request decode: sign extraction and magnitudes
  // ---------------------------------------------------------------------
  logic               sign_a;
  logic               sign_b;
  logic [p_nbits-1:0] mag_a;
  logic [p_nbits-1:0] mag_b;
  logic               accept;

  always_comb begin
    sign_a = func_signed_a(io.in_func) & io.in_a[p_nbits-1];
    sign_b = func_signed_b(io.in_func) & io.in_b[p_nbits-1];
    // Two's complement negation of the most negative value yields
    // 2^(p_nbits-1), which is exactly its unsigned magnitude.
    mag_a  = sign_a ? (~io.in_a + 1'b1) : io.in_a;
    mag_b  = sign_b ? (~io.in_b + 1'b1) : io.in_b;
  end

  assign accept = (state == st_idle) && io.in_val;

  // ---------------------------------------------------------------------
  // Iteration step: skip trailing zeros of the low multiplier window
  // ---------------------------------------------------------------------
  logic [zw-1:0]        tz;
  logic                 skip_all;
  logic [zw-1:0]        shamt;
  logic [2*p_nbits-1:0] add_term;

  imul_trailing_zero_count #(
    .p_nbits_in (p_skip_max)
  ) u_tzc (
    .bits  (b_reg[p_skip_max-1:0]),
    .count (tz)
  );

  always_comb begin
    skip_all = (tz == zw'(p_skip_max));
    // After consuming the set bit at position tz the loop moves past it,
    // hence tz+1; a fully zero window just slides by the window size.
    shamt    = skip_all ? zw'(p_skip_max) : (tz + 1'b1);
    add_term = a_reg << tz;
  end

  // ---------------------------------------------------------------------
  // FSM and datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= st_idle;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      neg_reg    <= 1'b0;
      func_reg   <= '0;
    end else begin
      case (state)
        st_idle: begin
          if (accept) begin
            a_reg      <= {{p_nbits{1'b0}}, mag_a};
            b_reg      <= mag_b;
            neg_reg    <= sign_a ^ sign_b;
            result_reg <= '0;
            func_reg   <= io.in_func;
            state      <= st_calc;
          end
        end
        st_calc: begin
          if (b_reg == '0) begin
            state <= st_fix;
          end else begin
            if (!skip_all) result_reg <= result_reg + add_term;
            a_reg <= a_reg << shamt;
            b_reg <= b_reg >> shamt;
          end
        end
        st_fix: begin
          result_reg <= neg_reg ? (~result_reg + 1'b1) : result_reg;
          state      <= st_done;
        end
        st_done: begin
          if (io.out_rdy) state <= st_idle;
        end
        default: state <= st_idle;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  always_comb begin
    // Reset forces IDLE asynchronously; mask in_rdy so nothing is
    // accepted while reset is still held.
    io.in_rdy  = (state == st_idle) && !reset;
    io.out_val = (state == st_done);
    io.out_msg = '0;
    if (state == st_done) begin
      io.out_msg = (func_reg == func_mul) ? result_reg[p_nbits-1:0]
                                          : result_reg[2*p_nbits-1:p_nbits];
    end
  end

  // ---------------------------------------------------------------------
  // Handshake signals must never be unknown outside reset
  // ---------------------------------------------------------------------
  a_hs_known: assert property (@(posedge clk) disable iff (reset)
    !$isunknown({io.in_val, io.out_rdy, io.in_rdy, io.out_val}));

endmodule

// File: tb/tb_imul_var_lat_param.sv
module tb_imul_var_lat_param;
  import imul_var_lat_param_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  imul_var_lat_param_if #(.p_nbits(32)) bus ();

  imul_var_lat_param #(
    .p_nbits    (32),
    .p_skip_max (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for in_rdy, then hold in_val for the accepting edge.
  task automatic issue(input string tag, input logic [1:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    int n;
    bus.in_val  = 1'b1;
    bus.in_func = f;
    bus.in_a    = a;
    bus.in_b    = b;
    n = 0;
    while (!bus.in_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rdy"}, 32'(bus.in_rdy), 32'd1);
    @(posedge clk);
    #1 bus.in_val = 1'b0;
  endtask

  // Count cycles after the accepting edge until out_val is seen.
  task automatic wait_resp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_val && lat < 100);
  endtask

  task automatic run_op(input string tag, input logic [1:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_msg, input int exp_lat);
    int lat;
    issue(tag, f, a, b);
    wait_resp(lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_val"}, 32'(bus.out_val), 32'd1);
    check({tag, "_msg"}, bus.out_msg, exp_msg);
    @(negedge clk);
    check({tag, "_idle"}, 32'(bus.out_val), 32'd0);
  endtask

  initial begin
    int lat;
    bus.in_val  = 1'b0;
    bus.in_func = func_mul;
    bus.in_a    = '0;
    bus.in_b    = '0;
    bus.out_rdy = 1'b1;

    // reset state
    @(negedge clk);
    check("rst_in_rdy",  32'(bus.in_rdy),  32'd0);
    check("rst_out_val", 32'(bus.out_val), 32'd0);
    check("rst_out_msg", bus.out_msg,      32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_in_rdy", 32'(bus.in_rdy), 32'd1);

    // directed vectors: tag, func, a, b, expected, latency
    run_op("mul_3x5",      func_mul,    32'd3,        32'd5,        32'h0000000F, 5);
    run_op("mul_skip8",    func_mul,    32'd3,        32'h00000100, 32'h00000300, 5);
    run_op("mulh_min",     func_mulh,   32'h80000000, 32'h80000000, 32'h40000000, 7);
    run_op("mul_ones",     func_mul,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 35);
    run_op("mulh_m1",      func_mulh,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4);
    run_op("mulhu_ones",   func_mulhu,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 35);
    run_op("mulhsu_ones",  func_mulhsu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 35);
    run_op("mul_b0",       func_mul,    32'h12345678, 32'd0,        32'h00000000, 3);
    run_op("mulhu_b31",    func_mulhu,  32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 7);
    run_op("mul_neg3x7",   func_mul,    32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 6);
    run_op("mulh_neg3x7",  func_mulh,   32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 6);
    run_op("mulhsu_min2",  func_mulhsu, 32'h80000000, 32'd2,        32'hFFFFFFFF, 4);

    // backpressure: response held while out_rdy low, in_val held high
    bus.out_rdy = 1'b0;
    issue("bp", func_mul, 32'd3, 32'd5);
    bus.in_val = 1'b1;
    bus.in_a   = 32'd7;
    bus.in_b   = 32'd6;
    wait_resp(lat);
    check("bp_lat", 32'(lat), 32'd5);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_val", 32'(bus.out_val), 32'd1);
      check("bp_hold_msg", bus.out_msg, 32'h0000000F);
      check("bp_hold_rdy", 32'(bus.in_rdy), 32'd0);
      @(negedge clk);
    end
    bus.out_rdy = 1'b1;
    @(negedge clk);
    check("bp_rel_val", 32'(bus.out_val), 32'd0);
    check("bp_rel_rdy", 32'(bus.in_rdy),  32'd1);
    @(posedge clk);
    #1 bus.in_val = 1'b0;
    wait_resp(lat);
    check("bp_next_lat", 32'(lat), 32'd5);
    check("bp_next_msg", bus.out_msg, 32'h0000002A);
    @(negedge clk);

    // reset mid-CALC aborts the operation
    issue("abort", func_mulhu, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_out_val", 32'(bus.out_val), 32'd0);
    check("abort_out_msg", bus.out_msg,      32'd0);
    check("abort_in_rdy",  32'(bus.in_rdy),  32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_rdy_after", 32'(bus.in_rdy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("abort_no_resp", 32'(bus.out_val), 32'd0);
      @(negedge clk);
    end
    run_op("post_abort", func_mul, 32'd3, 32'd5, 32'h0000000F, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
